// File: rtl/n2_rf_pkg.sv
// Shared types and helpers for the parametrised two-port register file.
package n2_rf_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    // Address width for a given depth, never narrower than one bit.
    function automatic int rf_aw(input int depth);
        int a;
        a = $clog2(depth);
        return (a < 1) ? 1 : a;
    endfunction

endpackage

// File: rtl/n2_com_rf_init_ctl.sv
// Clear sequencer: walks every entry once after reset or init_req, then idles in RUN.
module n2_com_rf_init_ctl
    import n2_rf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          l2clk,
    input  logic          rst_l,
    input  logic          init_req,
    output logic          init_busy,
    output logic          run,
    output logic          clr_we,
    output logic [AW-1:0] clr_adr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_INIT: begin
                if (init_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RF_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_RUN: begin
                if (init_req) begin
                    state_d = RF_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        init_busy = (state_q == RF_INIT);
        clr_we    = (state_q == RF_INIT);
        run       = (state_q == RF_RUN);
        clr_adr   = cnt_q;
    end

endmodule

// File: rtl/n2_com_rf_2p_param.sv
// DEPTH x WIDTH 1R/1W register file with registered read, write bypass and hardware clear.
// Optional even-parity storage and checking is enabled by defining N2_RF_PARITY_EN.
module n2_com_rf_2p_param
    import n2_rf_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 84,
    parameter int BYPASS = 1,
    parameter int AW     = rf_aw(DEPTH)
) (
    input  logic             l2clk,
    input  logic             rst_l,
    input  logic             init_req,
    output logic             init_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_adr,
    input  logic [WIDTH-1:0] din,
    input  logic             tcu_array_wr_inhibit,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_adr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld
`ifdef N2_RF_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef N2_RF_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    // One extra bit so a power-of-two DEPTH does not truncate to zero.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic          run, clr_we;
    logic [AW-1:0] clr_adr;
    logic [SW-1:0] mem_q [DEPTH];
    logic [SW-1:0] wr_word, rd_word;
    logic          fwr, rd_ok, rd_in, hit;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;

    n2_com_rf_init_ctl #(.DEPTH(DEPTH), .AW(AW)) u_init_ctl (
        .l2clk     (l2clk),
        .rst_l     (rst_l),
        .init_req  (init_req),
        .init_busy (init_busy),
        .run       (run),
        .clr_we    (clr_we),
        .clr_adr   (clr_adr)
    );

`ifdef N2_RF_PARITY_EN
    assign wr_word = {^din, din};
`else
    assign wr_word = din;
`endif

    assign fwr   = run & wr_en & ~tcu_array_wr_inhibit & ({1'b0, wr_adr} < DEPTH_W);
    assign rd_ok = run & rd_en;
    assign rd_in = ({1'b0, rd_adr} < DEPTH_W);
    assign hit   = fwr & (rd_adr == wr_adr) & (BYPASS != 0);

    // Storage is deliberately not reset; the clear sequencer owns initialisation.
    always_ff @(posedge l2clk) begin
        if (clr_we)
            mem_q[clr_adr] <= '0;
        else if (fwr)
            mem_q[wr_adr] <= wr_word;
    end

    always_comb begin
        rd_word = '0;
        if (rd_in)
            rd_word = hit ? wr_word : mem_q[rd_adr];
    end

    always_comb begin
        dout_d = rd_ok ? rd_word[WIDTH-1:0] : dout_q;
        vld_d  = rd_ok;
    end

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;

`ifdef N2_RF_PARITY_EN
    logic perr_q, perr_d;

    // Any odd word (data plus stored parity) flags an error.
    assign perr_d = rd_ok & (^rd_word);

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l)
            perr_q <= 1'b0;
        else
            perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`endif

endmodule
